// File: rtl/mcs6530_bus_pkg.sv
// Shared types for the MCS6530 RRIOT bus initiator: command ops, FSM states,
// idle bus values and the queued command record.
package mcs6530_bus_pkg;

    typedef enum logic [1:0] {
        WRITE = 2'd0,
        READ  = 2'd1,
        RMW   = 2'd2,
        POLL  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        POLL_CHK,
        RESP
    } state_t;

    localparam logic [9:0] IDLE_ADDR = 10'h000;
    localparam logic [7:0] IDLE_DATA = 8'h00;

    typedef struct packed {
        op_t        op;
        logic       rs0;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] mask;
    } cmd_t;

endpackage

// File: rtl/mcs6530_bus_master_cmd_fifo.sv
// Command queue in front of the bus sequencer. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate count.
module cmd_fifo
    import mcs6530_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [AW:0]    wptr;
    logic [AW:0]    rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/mcs6530_bus_master.sv
// Host-side bus initiator for the MCS6530 RRIOT: pops queued commands and runs
// them as single-cycle read/write bus transactions with a response handshake.
module mcs6530_bus_master
    import mcs6530_bus_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int CMD_DEPTH = 4,
    parameter int POLL_MAX  = 256
) (
    input  logic       phi2,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_rs0,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_mask,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic [9:0] addr,
    output logic       rs0,
    output logic       cs1,
    output logic       r_w,
    output logic [7:0] data_o,
    input  logic [7:0] data_i,
    output logic       busy
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t         state, state_n;
    cmd_t           push_cmd, fifo_dout, cmd;
    logic           fifo_full, fifo_empty, push, pop;
    logic [7:0]     val;
    logic [1:0]     wcnt;
    logic [PW-1:0]  tries;
    logic           tmo;
    logic           last_wait, match, poll_last, bus_cyc;

    assign push_cmd  = '{op: op_t'(cmd_op), rs0: cmd_rs0, addr: cmd_addr,
                         wdata: cmd_wdata, mask: cmd_mask};
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;

    assign last_wait = (wcnt == 2'(RD_LAT - 1));
    assign match     = ((val ^ cmd.wdata) & cmd.mask) == 8'h00;
    assign poll_last = (tries == PW'(POLL_MAX - 1));
    assign bus_cyc   = (state == RD) || (state == WR);

    cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (phi2),
        .rst   (rst),
        .push  (push),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge phi2) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (!fifo_empty)
                          state_n = (fifo_dout.op == WRITE) ? WR : RD;
            RD:       state_n = RD_WAIT;
            RD_WAIT:  if (last_wait) begin
                          if (cmd.op == READ)
                              state_n = RESP;
                          else if (cmd.op == RMW)
                              state_n = WR;
                          else
                              state_n = POLL_CHK;
                      end
            WR:       state_n = RESP;
            POLL_CHK: state_n = (match || poll_last) ? RESP : RD;
            RESP:     if (rsp_valid && rsp_ready)
                          state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // val holds the write value, then the sampled/merged read value; it is
    // what the write cycle drives and what the response reports.
    always_ff @(posedge phi2) begin
        if (rst) begin
            cmd   <= '0;
            val   <= 8'h00;
            wcnt  <= 2'd0;
            tries <= '0;
            tmo   <= 1'b0;
        end else begin
            if (pop) begin
                cmd   <= fifo_dout;
                val   <= fifo_dout.wdata;
                tries <= '0;
                tmo   <= 1'b0;
            end
            if (state == RD)
                wcnt <= 2'd0;
            if (state == RD_WAIT) begin
                if (last_wait)
                    val <= (cmd.op == RMW) ? ((data_i & ~cmd.mask) | (cmd.wdata & cmd.mask))
                                           : data_i;
                else
                    wcnt <= wcnt + 2'd1;
            end
            if ((state == POLL_CHK) && !match) begin
                tries <= tries + 1'b1;
                tmo   <= poll_last;
            end
        end
    end

    // Outputs are registered copies of the current state, so the bus cycle
    // appears one clock after the FSM enters RD/WR.
    always_ff @(posedge phi2) begin
        if (rst) begin
            addr        <= IDLE_ADDR;
            rs0         <= 1'b0;
            cs1         <= 1'b0;
            r_w         <= 1'b1;
            data_o      <= IDLE_DATA;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            addr      <= bus_cyc ? cmd.addr : IDLE_ADDR;
            rs0       <= bus_cyc && cmd.rs0;
            cs1       <= bus_cyc;
            r_w       <= (state != WR);
            data_o    <= (state == WR) ? val : IDLE_DATA;
            rsp_valid <= (state == RESP) && !(rsp_valid && rsp_ready);
            if (state == RESP) begin
                rsp_data    <= val;
                rsp_timeout <= tmo;
            end
            busy      <= (state != IDLE) || !fifo_empty;
        end
    end

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Bench for mcs6530_bus_master: directed literal cases plus randomized command
// streams checked every cycle against a transaction-script reference model.
module tb_mcs6530_bus_master;
    import mcs6530_bus_pkg::*;

    localparam int RD_LAT    = 1;
    localparam int CMD_DEPTH = 4;
    localparam int POLL_MAX  = 8;
    localparam logic [1:0] K_IDLE = 2'd0, K_RD = 2'd1, K_WR = 2'd2, K_RESP = 2'd3;

    logic       phi2 = 1'b0, rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_rs0 = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [9:0] cmd_addr = '0, addr;
    logic [7:0] cmd_wdata = '0, cmd_mask = '0, rsp_data, data_o, data_i;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_timeout, rs0, cs1, r_w, busy;

    always #5 phi2 = ~phi2;

    mcs6530_bus_master #(.RD_LAT(RD_LAT), .CMD_DEPTH(CMD_DEPTH), .POLL_MAX(POLL_MAX)) dut (
        .phi2(phi2), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs0(cmd_rs0), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_mask(cmd_mask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .addr(addr), .rs0(rs0),
        .cs1(cs1), .r_w(r_w), .data_o(data_o), .data_i(data_i), .busy(busy)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge phi2) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // RRIOT stand-in: each read bus cycle returns the next queued byte,
    // presented RD_LAT-1 cycles later; other cycles carry junk.
    logic [7:0] rd_q[$];
    logic [7:0] dl[RD_LAT];
    initial begin
        data_i = 8'h00;
        for (int i = 0; i < RD_LAT; i++) dl[i] = 8'h00;
        forever begin
            @(negedge phi2);
            for (int i = RD_LAT - 1; i > 0; i--) dl[i] = dl[i-1];
            if (cs1 === 1'b1 && r_w === 1'b1 && rd_q.size() > 0) dl[0] = rd_q.pop_front();
            else dl[0] = 8'($urandom);
            data_i = dl[RD_LAT-1];
        end
    end

    // Reference model: each popped command expands into a script of visible
    // output slots; the response slot repeats until it is accepted.
    typedef struct packed {
        logic [1:0] kind; logic [9:0] addr; logic rs0; logic [7:0] data; logic tmo;
    } slot_t;
    typedef struct packed {
        logic [1:0] op; logic rs0; logic [9:0] addr; logic [7:0] wd; logic [7:0] mk;
    } mc_t;

    mc_t        mq[$];
    logic [7:0] mv_q[$];
    slot_t      script[$];
    slot_t      cur;
    bit         active;
    logic [7:0] e_rdata;
    logic       e_tmo;
    bit         e_busy;

    function automatic slot_t sl(input logic [1:0] k, input logic [9:0] a, input logic r,
                                 input logic [7:0] d, input logic t);
        sl = '{kind: k, addr: a, rs0: r, data: d, tmo: t};
    endfunction

    function automatic logic [7:0] getv();
        getv = (mv_q.size() > 0) ? mv_q.pop_front() : 8'h00;
    endfunction

    task automatic build(input mc_t c);
        logic [7:0] v, n;
        script.delete();
        script.push_back(sl(K_IDLE, 0, 0, 0, 0));
        case (c.op)
            2'd0: begin
                script.push_back(sl(K_WR, c.addr, c.rs0, c.wd, 0));
                script.push_back(sl(K_RESP, 0, 0, c.wd, 0));
            end
            2'd1: begin
                v = getv();
                script.push_back(sl(K_RD, c.addr, c.rs0, 0, 0));
                repeat (RD_LAT) script.push_back(sl(K_IDLE, 0, 0, 0, 0));
                script.push_back(sl(K_RESP, 0, 0, v, 0));
            end
            2'd2: begin
                v = getv();
                n = (v & ~c.mk) | (c.wd & c.mk);
                script.push_back(sl(K_RD, c.addr, c.rs0, 0, 0));
                repeat (RD_LAT) script.push_back(sl(K_IDLE, 0, 0, 0, 0));
                script.push_back(sl(K_WR, c.addr, c.rs0, n, 0));
                script.push_back(sl(K_RESP, 0, 0, n, 0));
            end
            default: begin
                for (int i = 0; i < POLL_MAX; i++) begin
                    v = getv();
                    script.push_back(sl(K_RD, c.addr, c.rs0, 0, 0));
                    repeat (RD_LAT + 1) script.push_back(sl(K_IDLE, 0, 0, 0, 0));
                    if (((v ^ c.wd) & c.mk) == 8'h00) begin
                        script.push_back(sl(K_RESP, 0, 0, v, 0));
                        break;
                    end
                    if (i == POLL_MAX - 1) script.push_back(sl(K_RESP, 0, 0, v, 1));
                end
            end
        endcase
    endtask

    initial begin
        bit rdy_pre, was_busy, push;
        mc_t nc;
        cur = sl(K_IDLE, 0, 0, 0, 0);
        active = 0; e_rdata = 0; e_tmo = 0; e_busy = 0;
        forever begin
            @(posedge phi2);
            if (rst) begin
                mq.delete(); mv_q.delete(); script.delete();
                active = 0; cur = sl(K_IDLE, 0, 0, 0, 0);
                e_rdata = 0; e_tmo = 0; e_busy = 0;
            end else begin
                rdy_pre  = mq.size() < CMD_DEPTH;
                was_busy = active || (mq.size() > 0);
                push     = cmd_valid && rdy_pre;
                nc       = '{op: cmd_op, rs0: cmd_rs0, addr: cmd_addr, wd: cmd_wdata, mk: cmd_mask};
                if (active) begin
                    if (cur.kind == K_RESP) begin
                        if (rsp_ready) begin active = 0; cur = sl(K_IDLE, 0, 0, 0, 0); end
                    end else if (script.size() > 0) cur = script.pop_front();
                end else if (mq.size() > 0) begin
                    build(mq.pop_front());
                    cur = script.pop_front();
                    active = 1;
                end
                if (push) mq.push_back(nc);
                if (cur.kind == K_RESP) begin e_rdata = cur.data; e_tmo = cur.tmo; end
                e_busy = was_busy;
            end
            #1;
            check("bus", {addr, rs0, cs1, r_w, data_o},
                  {cur.addr, cur.rs0, cur.kind == K_RD || cur.kind == K_WR, cur.kind != K_WR,
                   (cur.kind == K_WR) ? cur.data : 8'h00});
            check("rsp", {rsp_valid, rsp_data, rsp_timeout}, {cur.kind == K_RESP, e_rdata, e_tmo});
            check("cmd_ready", cmd_ready, mq.size() < CMD_DEPTH);
            check("busy", busy, e_busy);
        end
    end

    // Stimulus helpers
    logic [7:0] pv[$];
    bit rand_rdy = 0;
    initial forever begin
        @(negedge phi2);
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic step(input int n);
        repeat (n) @(posedge phi2);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic r, input logic [9:0] a,
                         input logic [7:0] wd, input logic [7:0] mk, output int t);
        int waited = 0;
        bit r_now;
        @(negedge phi2);
        cmd_valid = 1; cmd_op = op; cmd_rs0 = r; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
        forever begin
            r_now = (cmd_ready === 1'b1);
            step(1);
            if (r_now) break;
            if (++waited > 300) begin
                n_chk++; n_fail++;
                $display("FAIL push_timeout: cmd_ready stayed %b, required 1", cmd_ready);
                break;
            end
        end
        t = cyc;
        cmd_valid = 0;
        while (pv.size() > 0) begin
            rd_q.push_back(pv[0]);
            mv_q.push_back(pv.pop_front());
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            step(1);
            if (busy === 1'b0 && rsp_valid === 1'b0) break;
            if (++n > 400) begin
                n_chk++; n_fail++;
                $display("FAIL idle_timeout: busy=%b rsp_valid=%b, required 0/0", busy, rsp_valid);
                break;
            end
        end
        step(2);
    endtask

    task automatic count_reads(output int reads);
        reads = 0;
        for (int n = 0; n < 300; n++) begin
            step(1);
            if (cs1 === 1'b1 && r_w === 1'b1) reads++;
            if (rsp_valid === 1'b1) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t, reads, seen;
        logic [1:0] op;
        logic [7:0] wd, mk, v, lsb;
        int k, nv;

        repeat (3) begin
            step(1);
            check("rst_bus", {addr, rs0, cs1, r_w, data_o}, {10'h0, 1'b0, 1'b0, 1'b1, 8'h00});
            check("rst_flags", {cmd_ready, busy, rsp_valid}, 3'b100);
        end
        @(negedge phi2) rst = 0;

        // WRITE
        issue(2'd0, 1'b1, 10'h201, 8'hA5, 8'h00, t);
        step(2);
        check("wr_bus", {addr, rs0, cs1, r_w, data_o}, {10'h201, 1'b1, 1'b1, 1'b0, 8'hA5});
        step(1);
        check("wr_rsp", {rsp_valid, rsp_data, cs1}, {1'b1, 8'hA5, 1'b0});
        wait_idle();

        // READ, RD_LAT=1
        pv.push_back(8'h3C);
        issue(2'd1, 1'b0, 10'h080, 8'h00, 8'h00, t);
        step(2);
        check("rd_bus", {addr, cs1, r_w}, {10'h080, 1'b1, 1'b1});
        step(1);
        check("rd_single", cs1, 1'b0);
        step(1);
        check("rd_rsp", {rsp_valid, rsp_data}, {1'b1, 8'h3C});
        wait_idle();

        // RMW
        pv.push_back(8'hF0);
        issue(2'd2, 1'b0, 10'h005, 8'h0F, 8'h03, t);
        step(2);
        check("rmw_rd", {cs1, r_w}, 2'b11);
        step(2);
        check("rmw_wr", {cs1, r_w, data_o}, {1'b1, 1'b0, 8'hF3});
        step(1);
        check("rmw_rsp", {rsp_valid, rsp_data}, {1'b1, 8'hF3});
        wait_idle();

        // POLL matching on the third read
        pv = '{8'h00, 8'h7F, 8'h80};
        issue(2'd3, 1'b0, 10'h010, 8'h80, 8'h80, t);
        count_reads(reads);
        check("poll_reads", reads, 3);
        check("poll_rsp", {rsp_valid, rsp_data, rsp_timeout}, {1'b1, 8'h80, 1'b0});
        wait_idle();

        // POLL never matching -> timeout after POLL_MAX reads
        for (int i = 0; i < POLL_MAX; i++) pv.push_back(8'(i * 5));
        issue(2'd3, 1'b0, 10'h010, 8'h80, 8'h80, t);
        count_reads(reads);
        check("poll_to_reads", reads, POLL_MAX);
        check("poll_to_rsp", {rsp_valid, rsp_data, rsp_timeout}, {1'b1, 8'(35), 1'b1});
        wait_idle();

        // Fill: one in flight, four queued, sixth refused; then reset mid-POLL
        @(negedge phi2) rsp_ready = 0;
        for (int i = 0; i < POLL_MAX; i++) pv.push_back(8'h01);
        issue(2'd3, 1'b0, 10'h040, 8'h80, 8'h80, t);
        for (int i = 0; i < 4; i++) issue(2'd0, 1'b0, 10'(i), 8'(i), 8'h00, t);
        @(negedge phi2);
        cmd_valid = 1; cmd_op = 2'd0;
        check("full_refused", cmd_ready, 1'b0);
        step(1);
        cmd_valid = 0;
        check("full_busy", {cmd_ready, busy}, 2'b01);
        @(negedge phi2) rst = 1;
        step(1);
        rd_q.delete();
        check("midrst_bus", {addr, rs0, cs1, r_w, data_o}, {10'h0, 1'b0, 1'b0, 1'b1, 8'h00});
        check("midrst_flags", {cmd_ready, busy, rsp_valid}, 3'b100);
        @(negedge phi2) begin rst = 0; rsp_ready = 1; end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (cs1 === 1'b1 || rsp_valid === 1'b1) seen++;
        end
        check("midrst_quiet", seen, 0);

        // Randomized command stream with random response back-pressure
        rand_rdy = 1;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            wd = 8'($urandom);
            mk = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if (op == 2'd1 || op == 2'd2) pv.push_back(8'($urandom));
            if (op == 2'd3) begin
                k  = $urandom_range(1, POLL_MAX + 1);
                if (mk == 8'h00) k = 1;
                nv = (k > POLL_MAX) ? POLL_MAX : k;
                lsb = mk & (~mk + 8'd1);
                for (int i = 0; i < nv; i++) begin
                    v = 8'($urandom);
                    if (i == k - 1) v = (v & ~mk) | (wd & mk);
                    else if (((v ^ wd) & mk) == 8'h00) v = v ^ lsb;
                    pv.push_back(v);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge phi2);
            issue(op, 1'($urandom), 10'($urandom), wd, mk, t);
        end
        wait_idle();
        rand_rdy = 0;
        @(negedge phi2) rsp_ready = 1;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
